// File: rtl/io_responder.sv
// Memory-mapped IO target: LED register, 64-bit cycle timer and an 8N1 UART
// transmitter fed by a small TX FIFO. Reads are combinational from the address.
module io_responder #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] IO_memAddr_i,
  input  logic [31:0] IO_memWData_i,
  input  logic        IO_memWr_i,
  output logic [31:0] IO_memRData_o,
  output logic        uart_tx_o,
  output logic [7:0]  leds_o
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  typedef struct packed {
    logic [23:0] rsvd;
    logic [3:0]  count;
    logic        ovf;
    logic        busy;
    logic        tx_idle;
    logic        full;
  } status_t;

  logic [2:0]    sel;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic [63:0]   mtime;
  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          full, push_req, pop, push, ovf_set, ovf_clr, baud_last;
  status_t       status;
  logic          unused_bits;

  assign unused_bits = ^{IO_memAddr_i[31:5], IO_memAddr_i[1:0], IO_memWData_i[31:8]};

  assign sel       = IO_memAddr_i[4:2];
  assign full      = (count == CW'(FIFO_DEPTH));
  assign push_req  = IO_memWr_i && (sel == 3'd1);
  // The transmitter drains the head only while idle; that same-cycle pop frees a slot.
  assign pop       = (state == IDLE) && (count != '0);
  assign push      = push_req && (!full || pop);
  assign ovf_set   = push_req && full && !pop;
  assign ovf_clr   = IO_memWr_i && (sel == 3'd2) && IO_memWData_i[3];
  assign baud_last = (baud_cnt == BW'(DIV - 1));

  always_comb begin
    status         = '0;
    status.count   = 4'(count);
    status.ovf     = ovf;
    status.busy    = (state != IDLE);
    status.tx_idle = (state == IDLE) && (count == '0);
    status.full    = full;
  end

  always_comb begin
    IO_memRData_o = '0;
    case (sel)
      3'd0:    IO_memRData_o = {24'd0, leds_o};
      3'd2:    IO_memRData_o = status;
      3'd3:    IO_memRData_o = mtime[31:0];
      3'd4:    IO_memRData_o = mtime[63:32];
      default: IO_memRData_o = '0;
    endcase
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr] <= IO_memWData_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      leds_o    <= '0;
      uart_tx_o <= 1'b1;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      mtime     <= '0;
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_q   <= '0;
    end else begin
      mtime <= mtime + 64'd1;
      if (IO_memWr_i && (sel == 3'd0)) leds_o <= IO_memWData_i[7:0];
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;

      case (state)
        IDLE: begin
          uart_tx_o <= 1'b1;
          if (pop) begin
            shift_q   <= fifo_mem[rptr];
            bit_idx   <= '0;
            baud_cnt  <= '0;
            uart_tx_o <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt  <= '0;
            uart_tx_o <= shift_q[0];
            state     <= DATA;
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx_o <= 1'b1;
              state     <= STOP;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shift_q   <= shift_q >> 1;
              uart_tx_o <= shift_q[1];
            end
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
